// File: rtl/dff_deser.sv
// Serial-to-parallel deserializer: hunts for SYNC_WORD, then emits FRAME_WORDS
// MSB-first words on a valid/ready port and counts words lost to backpressure.
module dff_deser #(
    parameter int unsigned          WORD_W      = 8,
    parameter logic [WORD_W-1:0]    SYNC_WORD   = 8'hA5,
    parameter int unsigned          FRAME_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              locked,
    output logic [15:0]       ovf_cnt,
    input  logic              ovf_clr
);

    localparam int unsigned BCW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam int unsigned WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    // Only the low WORD_W-1 bits of history can influence the next word.
    logic [WORD_W-2:0]   r_hist;
    logic [BCW-1:0]      r_bit_cnt;
    logic [WCW-1:0]      r_word_cnt;
    logic                r_locked;
    logic [WORD_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_out_last;
    logic [15:0]         r_ovf_cnt;

    logic [WORD_W-1:0]   w_nxt;
    logic                w_word_done;
    logic                w_word_last;
    logic                w_accept;
    logic                w_drop;

    assign w_nxt       = {r_hist, bit_in};
    assign w_word_done = (r_state == ST_LOCKED) && bit_en && (r_bit_cnt == BIT_LAST);
    assign w_word_last = w_word_done && (r_word_cnt == WORD_LAST);
    assign w_accept    = !r_out_valid || out_ready;
    assign w_drop      = w_word_done && !w_accept;

    // Sync hunt / framing state machine and bit/word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_hist     <= {(WORD_W-1){1'b0}};
            r_bit_cnt  <= {BCW{1'b0}};
            r_word_cnt <= {WCW{1'b0}};
            r_locked   <= 1'b0;
        end else if (bit_en) begin
            case (r_state)
                ST_HUNT: begin
                    r_hist <= w_nxt[WORD_W-2:0];
                    if (w_nxt == SYNC_WORD) begin
                        r_state    <= ST_LOCKED;
                        r_locked   <= 1'b1;
                        r_bit_cnt  <= {BCW{1'b0}};
                        r_word_cnt <= {WCW{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= {BCW{1'b0}};
                        if (r_word_cnt == WORD_LAST) begin
                            r_state    <= ST_HUNT;
                            r_locked   <= 1'b0;
                            r_word_cnt <= {WCW{1'b0}};
                            r_hist     <= {(WORD_W-1){1'b0}};
                        end else begin
                            r_word_cnt <= r_word_cnt + WCW'(1);
                            r_hist     <= w_nxt[WORD_W-2:0];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                        r_hist    <= w_nxt[WORD_W-2:0];
                    end
                end
                default: begin
                    r_state  <= ST_HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register with same-edge handoff under ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= {WORD_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_word_done) begin
            if (w_accept) begin
                r_out_data  <= w_nxt;
                r_out_last  <= w_word_last;
                r_out_valid <= 1'b1;
            end
        end else if (out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // Saturating drop counter; clear takes priority over a same-cycle drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= 16'd0;
        end else if (ovf_clr) begin
            r_ovf_cnt <= 16'd0;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign locked    = r_locked;
    assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_dff_deser.sv
// Directed self-checking bench for dff_deser (WORD_W=8, SYNC_WORD=A5, FRAME_WORDS=4).
module tb_dff_deser;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        bit_en;
    logic        out_ready;
    logic        ovf_clr;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        locked;
    logic [15:0] ovf_cnt;

    int n_cmp = 0;
    int n_err = 0;

    dff_deser #(.WORD_W(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(4)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .locked(locked), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Drive one bit for one clock; returns 1 time unit after the sampling edge.
    task automatic send_bit(input logic b, input logic en);
        bit_in = b;
        bit_en = en;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(b[i], 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bit_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_in = 1'b0; bit_en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", out_last); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", locked); end
        n_cmp++; if (ovf_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_ovf got %h want 0000", ovf_cnt); end
        do_reset();
    endtask

    task automatic test_basic();
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        out_ready = 1'b1;
        send_range(8'hA5, 7, 1);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL basic_lock_early got %b want 0", locked); end
        send_range(8'hA5, 0, 0);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL basic_lock got %b want 1", locked); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_sync_hidden got %b want 0", out_valid); end
        for (int k = 0; k < 4; k++) begin
            send_range(words[k], 7, 1);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid w%0d got %b want 0", k, out_valid); end
            send_range(words[k], 0, 0);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid w%0d got %b want 1", k, out_valid); end
            n_cmp++; if (out_data !== words[k]) begin n_err++; $display("FAIL basic_data w%0d got %h want %h", k, out_data, words[k]); end
            n_cmp++; if (out_last !== (k == 3)) begin n_err++; $display("FAIL basic_last w%0d got %b want %b", k, out_last, (k == 3)); end
            n_cmp++; if (locked !== (k != 3)) begin n_err++; $display("FAIL basic_locked w%0d got %b want %b", k, locked, (k != 3)); end
        end
        send_bit(1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b want 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL basic_last_clr got %b want 0", out_last); end
    endtask

    task automatic test_gapped();
        logic [7:0] words [5];
        words[0] = 8'hA5; words[1] = 8'h11; words[2] = 8'h22; words[3] = 8'h33; words[4] = 8'h44;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 7; i >= 1; i--) begin
                send_bit(words[k][i], 1'b1);
                send_bit(~words[k][i], 1'b0);
            end
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_early_valid w%0d got %b want 0", k, out_valid); end
            send_bit(words[k][0], 1'b1);
            if (k == 0) begin
                n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL gap_lock got %b want 1", locked); end
            end else begin
                n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid w%0d got %b want 1", k, out_valid); end
                n_cmp++; if (out_data !== words[k]) begin n_err++; $display("FAIL gap_data w%0d got %h want %h", k, out_data, words[k]); end
                n_cmp++; if (out_last !== (k == 4)) begin n_err++; $display("FAIL gap_last w%0d got %b want %b", k, out_last, (k == 4)); end
            end
            send_bit(~words[k][0], 1'b0);
            n_cmp++; if (locked !== (k != 4)) begin n_err++; $display("FAIL gap_hold w%0d got %b want %b", k, locked, (k != 4)); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_range(8'hA5, 7, 0);
        send_range(8'h11, 7, 0);
        n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL bp_first got %h want 11", out_data); end
        send_range(8'h22, 7, 0);
        send_range(8'h33, 7, 0);
        n_cmp++; if (ovf_cnt !== 16'd2) begin n_err++; $display("FAIL bp_ovf_mid got %0d want 2", ovf_cnt); end
        send_range(8'h44, 7, 0);
        n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL bp_held got %h want 11", out_data); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL bp_last got %b want 0", out_last); end
        n_cmp++; if (ovf_cnt !== 16'd3) begin n_err++; $display("FAIL bp_ovf got %0d want 3", ovf_cnt); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL bp_unlock got %b want 0", locked); end
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
        ovf_clr = 1'b1;
        send_bit(1'b0, 1'b0);
        ovf_clr = 1'b0;
        n_cmp++; if (ovf_cnt !== 16'd0) begin n_err++; $display("FAIL bp_clr got %0d want 0", ovf_cnt); end
        out_ready = 1'b0;
        send_range(8'hA5, 7, 0);
        send_range(8'h11, 7, 0);
        send_range(8'h22, 7, 0);
        n_cmp++; if (ovf_cnt !== 16'd1) begin n_err++; $display("FAIL bp_ovf2 got %0d want 1", ovf_cnt); end
        send_range(8'h33, 7, 1);
        ovf_clr = 1'b1;
        send_range(8'h33, 0, 0);
        ovf_clr = 1'b0;
        n_cmp++; if (ovf_cnt !== 16'd0) begin n_err++; $display("FAIL bp_clr_wins got %0d want 0", ovf_cnt); end
        send_range(8'h44, 7, 0);
        n_cmp++; if (ovf_cnt !== 16'd1) begin n_err++; $display("FAIL bp_ovf3 got %0d want 1", ovf_cnt); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL bp_unlock2 got %b want 0", locked); end
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0);
    endtask

    task automatic test_false_sync();
        out_ready = 1'b1;
        send_range(8'hA5, 7, 0);
        for (int k = 0; k < 4; k++) begin
            send_range(8'hA5, 7, 0);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_err++; $display("FAIL fs_word w%0d got v=%b d=%h want v=1 d=a5", k, out_valid, out_data); end
            n_cmp++; if (out_last !== (k == 3)) begin n_err++; $display("FAIL fs_last w%0d got %b want %b", k, out_last, (k == 3)); end
        end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL fs_unlock got %b want 0", locked); end
        send_range(8'hA5, 7, 0);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL fs_relock got %b want 1", locked); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fs_sync_hidden got %b want 0", out_valid); end
        do_reset();
    endtask

    task automatic test_hunt_reject();
        logic [7:0] junk [3];
        logic       seen;
        junk[0] = 8'h5A; junk[1] = 8'hFF; junk[2] = 8'h00;
        seen = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(junk[k][i], 1'b1);
                if (locked !== 1'b0 || out_valid !== 1'b0) seen = 1'b1;
            end
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL hunt_reject got lock/valid=1 want 0"); end
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_range(8'hA5, 7, 1);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL hunt_offset_early got %b want 0", locked); end
        send_range(8'hA5, 0, 0);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL hunt_offset_lock got %b want 1", locked); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_range(8'hA5, 7, 0);
        send_range(8'h11, 7, 0);
        send_range(8'h22, 7, 0);
        send_range(8'h33, 7, 0);
        send_range(8'h44, 7, 0);
        send_range(8'hA5, 7, 0);
        send_range(8'h11, 7, 0);
        send_range(8'h22, 7, 5);
        n_cmp++; if (out_valid !== 1'b1 || locked !== 1'b1 || ovf_cnt !== 16'd4) begin
            n_err++; $display("FAIL rm_pre got v=%b l=%b o=%0d want v=1 l=1 o=4", out_valid, locked, ovf_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b want 0", out_valid); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rm_locked got %b want 0", locked); end
        n_cmp++; if (ovf_cnt !== 16'd0) begin n_err++; $display("FAIL rm_ovf got %0d want 0", ovf_cnt); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rm_data got %h want 00", out_data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_range(8'h22, 4, 0);
        send_range(8'h33, 7, 0);
        n_cmp++; if (locked !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rm_nolock got l=%b v=%b want 0 0", locked, out_valid);
        end
        send_range(8'hA5, 7, 0);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL rm_relock got %b want 1", locked); end
        send_range(8'h77, 7, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            n_err++; $display("FAIL rm_word got v=%b d=%h want v=1 d=77", out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_false_sync();
        test_hunt_reject();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
